// File: rtl/neuron_layer_train_sched.sv
// Sample/epoch sequencer for one neuron_learn layer: fetch, forward strobe,
// settle + capture, optional learn strobe, advance counters, done pulse.
module neuron_layer_train_sched #(
    parameter int BATCH         = 32,
    parameter int NUM_EPOCHS    = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int LEARN_CYCLES  = 1,
    parameter int SW            = $clog2(BATCH + 1),
    parameter int EW            = $clog2(NUM_EPOCHS + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic          infer_only,
    input  logic          abort,
    input  logic          sample_valid,
    output logic          sample_ready,
    output logic          layer_valid,
    output logic          layer_learn,
    output logic          capture_out,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] sample_idx,
    output logic [EW-1:0] epoch_idx
);

    localparam int TMAX = (SETTLE_CYCLES > LEARN_CYCLES) ?
                          SETTLE_CYCLES : LEARN_CYCLES;
    localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] T_SET  = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] T_LRN  = TW'(LEARN_CYCLES - 1);
    localparam logic [SW-1:0] S_LAST = SW'(BATCH - 1);
    localparam logic [EW-1:0] E_LAST = EW'(NUM_EPOCHS - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, FWD, SETTLE, LEARN, NEXT, DONE
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic          infer_q, infer_n;
    logic [SW-1:0] sidx_n;
    logic [EW-1:0] eidx_n;
    logic          ready_n, valid_n, learn_n;
    logic          cap_n, busy_n, done_n;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            timer        <= '0;
            infer_q      <= 1'b0;
            sample_idx   <= '0;
            epoch_idx    <= '0;
            sample_ready <= 1'b0;
            layer_valid  <= 1'b0;
            layer_learn  <= 1'b0;
            capture_out  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            infer_q      <= infer_n;
            sample_idx   <= sidx_n;
            epoch_idx    <= eidx_n;
            sample_ready <= ready_n;
            layer_valid  <= valid_n;
            layer_learn  <= learn_n;
            capture_out  <= cap_n;
            busy         <= busy_n;
            done         <= done_n;
        end
    end

    // abort overrides every transition; counters are left for debug
    always_comb begin
        state_n = state;
        timer_n = timer;
        infer_n = infer_q;
        sidx_n  = sample_idx;
        eidx_n  = epoch_idx;
        if (abort) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    state_n = FETCH;
                    infer_n = infer_only;
                    sidx_n  = '0;
                    eidx_n  = '0;
                end
                FETCH: if (sample_valid && sample_ready) begin
                    state_n = FWD;
                end
                FWD: begin
                    state_n = SETTLE;
                    timer_n = T_SET;
                end
                SETTLE: if (timer == '0) begin
                    state_n = infer_q ? NEXT : LEARN;
                    timer_n = T_LRN;
                end else begin
                    timer_n = timer - TW'(1);
                end
                LEARN: if (timer == '0) begin
                    state_n = NEXT;
                end else begin
                    timer_n = timer - TW'(1);
                end
                NEXT: if (sample_idx < S_LAST) begin
                    sidx_n  = sample_idx + SW'(1);
                    state_n = FETCH;
                end else begin
                    sidx_n = '0;
                    if (epoch_idx < E_LAST) begin
                        eidx_n  = epoch_idx + EW'(1);
                        state_n = FETCH;
                    end else begin
                        state_n = DONE;
                    end
                end
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // outputs decoded from the upcoming state so they leave a register
    always_comb begin
        ready_n = (state_n == FETCH);
        valid_n = (state_n == FWD);
        learn_n = (state_n == LEARN);
        cap_n   = (state_n == SETTLE) && (timer_n == '0);
        busy_n  = (state_n != IDLE);
        done_n  = (state_n == DONE);
    end

endmodule

// File: tb/tb_neuron_layer_train_sched.sv
// Bench for neuron_layer_train_sched: scenario table driving a schedule model
// that expands the epoch/sample loops into an expected per-cycle trace.
module tb_neuron_layer_train_sched;

    localparam int B   = 4;
    localparam int NE  = 2;
    localparam int SET = 2;
    localparam int LRN = 1;
    localparam int SW  = $clog2(B + 1);
    localparam int EW  = $clog2(NE + 1);

    localparam int PF = 1, PW = 2, PS = 3, PL = 4, PN = 5, PD = 6, PI = 7;

    typedef struct {
        bit rdy, lv, ln, cap, busy, dn;
        int sidx, eidx, ph;
    } exp_t;

    typedef struct {
        bit inf;
        int mode;
        int act;
        int ev, el, ec, ed, per;
    } vec_t;

    logic          clock = 0;
    logic          reset_n;
    logic          start, infer_only, abort, sample_valid;
    logic          sample_ready, layer_valid, layer_learn;
    logic          capture_out, busy, done;
    logic [SW-1:0] sample_idx;
    logic [EW-1:0] epoch_idx;

    int   tests = 0;
    int   failed = 0;
    exp_t tr[$];
    bit   vld[1024];
    vec_t vecs[10];

    neuron_layer_train_sched #(
        .BATCH(B), .NUM_EPOCHS(NE),
        .SETTLE_CYCLES(SET), .LEARN_CYCLES(LRN)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .infer_only(infer_only), .abort(abort),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .layer_valid(layer_valid), .layer_learn(layer_learn),
        .capture_out(capture_out), .busy(busy), .done(done),
        .sample_idx(sample_idx), .epoch_idx(epoch_idx)
    );

    always #5 clock = ~clock;

    function automatic void push(input bit r, lv, ln, cp, bz, dn,
                                 input int s, e, ph);
        exp_t x;
        x = '{r, lv, ln, cp, bz, dn, s, e, ph};
        tr.push_back(x);
    endfunction

    // one entry per clock cycle, straight from the epoch/sample loop nest
    function automatic void build(input bit inf);
        bit got;
        tr.delete();
        for (int e = 0; e < NE; e++) begin
            for (int s = 0; s < B; s++) begin
                got = 0;
                while (!got) begin
                    got = vld[tr.size()];
                    push(1, 0, 0, 0, 1, 0, s, e, PF);
                end
                push(0, 1, 0, 0, 1, 0, s, e, PW);
                for (int i = 0; i < SET; i++)
                    push(0, 0, 0, (i == SET - 1), 1, 0, s, e, PS);
                if (!inf)
                    for (int i = 0; i < LRN; i++)
                        push(0, 0, 1, 0, 1, 0, s, e, PL);
                push(0, 0, 0, 0, 1, 0, s, e, PN);
            end
        end
        push(0, 0, 0, 0, 1, 1, 0, NE - 1, PD);
        for (int i = 0; i < 3; i++)
            push(0, 0, 0, 0, 0, 0, 0, NE - 1, PI);
    endfunction

    task automatic chk(input string nm, input exp_t x, input int k);
        tests++;
        if ({sample_ready, layer_valid, layer_learn,
             capture_out, busy, done} !==
            {x.rdy, x.lv, x.ln, x.cap, x.busy, x.dn} ||
            int'(sample_idx) != x.sidx ||
            int'(epoch_idx) != x.eidx) begin
            failed++;
            $display("FAIL %s cyc %0d: got rdy%b lv%b ln%b cap%b bsy%b dn%b s%0d e%0d, want rdy%b lv%b ln%b cap%b bsy%b dn%b s%0d e%0d",
                     nm, k, sample_ready, layer_valid, layer_learn,
                     capture_out, busy, done, sample_idx, epoch_idx,
                     x.rdy, x.lv, x.ln, x.cap, x.busy, x.dn,
                     x.sidx, x.eidx);
        end
    endtask

    task automatic cnt(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            failed++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic run(input vec_t v);
        int   lim, ab, ms, nv, nl, nc, nd, last, pmin, pmax, fs;
        exp_t x;
        for (int i = 0; i < 1024; i++)
            vld[i] = (v.mode == 1 && i < 400) ?
                     ($urandom_range(0, 2) != 0) : 1'b1;
        if (v.mode == 2) begin
            fs = 2 * (3 + SET + (v.inf ? 0 : LRN));
            for (int i = fs; i < fs + 7; i++) vld[i] = 1'b0;
        end
        build(v.inf);
        ab = -1;
        ms = -1;
        for (int k = 0; k < tr.size(); k++) begin
            if (v.act == 1 && ab < 0 && tr[k].ph == PL &&
                tr[k].eidx == 1 && tr[k].sidx == 3) ab = k;
            if (v.act == 2 && ms < 0 && tr[k].ph == PN &&
                tr[k].eidx == 0 && tr[k].sidx == B - 1) ms = k;
        end
        lim = (ab >= 0) ? ab + 4 : tr.size();
        @(negedge clock);
        start = 1;
        infer_only = v.inf;
        sample_valid = 1'($urandom_range(0, 1));
        @(negedge clock);
        start = 0;
        infer_only = ~v.inf;
        nv = 0; nl = 0; nc = 0; nd = 0;
        last = -1; pmin = 1000; pmax = 0;
        for (int k = 0; k < lim; k++) begin
            if (ab >= 0 && k > ab) begin
                x = tr[ab];
                x.rdy = 0; x.lv = 0; x.ln = 0;
                x.cap = 0; x.busy = 0; x.dn = 0;
            end else begin
                x = tr[k];
            end
            chk("trace", x, k);
            if (layer_valid) begin
                nv++;
                if (last >= 0) begin
                    if (k - last < pmin) pmin = k - last;
                    if (k - last > pmax) pmax = k - last;
                end
                last = k;
            end
            if (layer_learn) nl++;
            if (capture_out) nc++;
            if (done) nd++;
            sample_valid = vld[k];
            abort = (k == ab);
            start = (k == ms);
            @(negedge clock);
        end
        abort = 0;
        start = 0;
        cnt("valid_pulses", nv, v.ev);
        cnt("learn_pulses", nl, v.el);
        cnt("capture_pulses", nc, v.ec);
        cnt("done_pulses", nd, v.ed);
        if (v.per > 0) begin
            cnt("period_min", pmin, v.per);
            cnt("period_max", pmax, v.per);
        end
    endtask

    initial begin
        exp_t z;
        z = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        // inf, mode(0 tied,1 rand,2 stall s2), act(1 abort,2 start mid-run)
        vecs[0] = '{0, 0, 0, 8, 8, 8, 1, 3 + SET + LRN};
        vecs[1] = '{1, 0, 0, 8, 0, 8, 1, 3 + SET};
        vecs[2] = '{0, 2, 0, 8, 8, 8, 1, 0};
        vecs[3] = '{0, 0, 1, 8, 8, 8, 0, 3 + SET + LRN};
        vecs[4] = '{0, 0, 0, 8, 8, 8, 1, 3 + SET + LRN};
        vecs[5] = '{0, 0, 2, 8, 8, 8, 1, 3 + SET + LRN};
        vecs[6] = '{0, 1, 0, 8, 8, 8, 1, 0};
        vecs[7] = '{1, 1, 0, 8, 0, 8, 1, 0};
        vecs[8] = '{0, 1, 2, 8, 8, 8, 1, 0};
        vecs[9] = '{1, 2, 0, 8, 0, 8, 1, 0};

        reset_n = 0;
        start = 1;
        infer_only = 1;
        abort = 0;
        sample_valid = 1;
        repeat (3) begin
            @(negedge clock);
            chk("reset", z, 0);
        end
        start = 0;
        reset_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("idle_after_reset", z, i);
        end

        foreach (vecs[i]) run(vecs[i]);

        @(negedge clock);
        start = 1;
        infer_only = 0;
        sample_valid = 1;
        @(negedge clock);
        start = 0;
        repeat (4) @(negedge clock);
        cnt("learn_before_reset", int'(layer_learn), 1);
        reset_n = 0;
        @(negedge clock);
        chk("mid_run_reset", z, 0);
        reset_n = 1;
        repeat (2) @(negedge clock);
        chk("idle_after_mid_reset", z, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
